// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type and defaults for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam int PC_INC_DEFAULT = 4;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - one-entry instruction/PC holding register with load and clear
module fetch_buf #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [N-1:0] instr_i,
    input  logic [N-1:0] pc_i,
    output logic [N-1:0] instr_o,
    output logic [N-1:0] pc_o
);
    logic [N-1:0] instr_q;
    logic [N-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding fetch sequencer driving the PC register and imem port
// Optional feature macro: FETCH_MISALIGN_CHK_EN (word-aligns redirect targets, pulses fetch_misalign)
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int N      = 32,
    parameter int PC_INC = PC_INC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_cur,
    output logic [N-1:0] pc_next,
    output logic         StallF,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    input  logic         stall_d,
    input  logic         redirect_e,
    input  logic [N-1:0] redirect_pc,
    output logic         instr_valid_d,
    output logic [N-1:0] instr_d,
    output logic [N-1:0] instr_pc_d,
    output logic         fetch_misalign
);
    fetch_state_t state_q, state_d;
    logic [N-1:0] redir_q, redir_d;
    logic         mis_q;
    logic         redir_evt;
    logic         buf_load, buf_clear;
    logic [N-1:0] buf_instr, buf_pc;
    logic [N-1:0] target, pc_seq;
    logic         misalign;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target   = {redirect_pc[N-1:2], 2'b00};
    assign misalign = (redirect_pc[1:0] != 2'b00);
`else
    assign target   = redirect_pc;
    assign misalign = 1'b0;
`endif

    assign pc_seq         = pc_cur + N'(PC_INC);
    assign imem_addr      = pc_cur;
    assign fetch_misalign = mis_q;

    fetch_buf #(.N(N)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .instr_i (imem_rdata),
        .pc_i    (pc_cur),
        .instr_o (buf_instr),
        .pc_o    (buf_pc)
    );

    // Outputs are Mealy so a returning word can flow straight through to decode.
    always_comb begin
        state_d       = state_q;
        redir_d       = redir_q;
        redir_evt     = 1'b0;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        StallF        = 1'b1;
        pc_next       = '0;
        imem_req      = 1'b0;
        instr_valid_d = 1'b0;
        instr_d       = buf_instr;
        instr_pc_d    = buf_pc;
        if (reset) begin
            instr_d    = '0;
            instr_pc_d = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_rvalid && redirect_e) begin
                        redir_evt = 1'b1;
                        pc_next   = target;
                        StallF    = 1'b0;
                    end else if (imem_rvalid && !stall_d) begin
                        instr_valid_d = 1'b1;
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_cur;
                        pc_next       = pc_seq;
                        StallF        = 1'b0;
                    end else if (imem_rvalid) begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end else if (redirect_e) begin
                        redir_evt = 1'b1;
                        redir_d   = target;
                        state_d   = DROP;
                    end
                end
                HOLD: begin
                    if (redirect_e) begin
                        redir_evt = 1'b1;
                        buf_clear = 1'b1;
                        pc_next   = target;
                        StallF    = 1'b0;
                        state_d   = FETCH;
                    end else begin
                        instr_valid_d = 1'b1;
                        if (!stall_d) begin
                            buf_clear = 1'b1;
                            pc_next   = pc_seq;
                            StallF    = 1'b0;
                            state_d   = FETCH;
                        end
                    end
                end
                DROP: begin
                    // The abandoned request is still in flight; wait it out before refetching.
                    if (redirect_e) begin
                        redir_evt = 1'b1;
                        redir_d   = target;
                    end
                    if (imem_rvalid) begin
                        pc_next = redirect_e ? target : redir_q;
                        StallF  = 1'b0;
                        state_d = FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            redir_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
            mis_q   <= redir_evt && misalign;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with a memory responder and PC register model
module tb_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        StallF;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall_d = 1'b0;
    logic        redirect_e = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid_d;
    logic [31:0] instr_d;
    logic [31:0] instr_pc_d;
    logic        fetch_misalign;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .StallF         (StallF),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall_d        (stall_d),
        .redirect_e     (redirect_e),
        .redirect_pc    (redirect_pc),
        .instr_valid_d  (instr_valid_d),
        .instr_d        (instr_d),
        .instr_pc_d     (instr_pc_d),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    // PC register of the surrounding pipeline
    always @(posedge clk) begin
        if (reset) pc_cur <= 32'h0;
        else if (!StallF) pc_cur <= pc_next;
    end

    int total = 0;
    int bad = 0;
    int delivered = 0;
    int timeouts = 0;

    // memory responder and architectural model state (written by stimulus only)
    logic        outst = 1'b0, kill = 1'b0;
    logic [31:0] maddr = '0;
    int          mwait = 0;
    int          lat = 1;
    bit          rand_lat = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] pend_tgt = '0;
    bit          prev_rst = 1'b1;
    bit          mis_prev = 1'b0;
    bit          started = 1'b0;

    // per-cycle expectations handed to the monitor
    bit          chk_en = 1'b0, end_chk = 1'b0;
    bit          e_free = 1'b0, e_req = 1'b0, e_valid = 1'b0, e_zero = 1'b0, e_mis = 1'b0;
    logic [31:0] e_pcn = '0;

    ent_t        exp_q[$];
    logic [31:0] dlog[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a == 32'h10) ? 32'h00500093 : ((a * 32'h9E3779B1) ^ 32'h13);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // monitor: compares what the DUT presents against the expectations and scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            chk("StallF", 32'(StallF), 32'(!e_free));
            chk("imem_req", 32'(imem_req), 32'(e_req));
            chk("instr_valid_d", 32'(instr_valid_d), 32'(e_valid));
            chk("fetch_misalign", 32'(fetch_misalign), 32'(e_mis));
            if (e_free) chk("pc_next", pc_next, e_pcn);
            if (e_zero) begin
                chk("pc_next_rst", pc_next, 32'h0);
                chk("instr_d_rst", instr_d, 32'h0);
                chk("instr_pc_d_rst", instr_pc_d, 32'h0);
            end
            if (imem_req) chk("imem_addr", imem_addr, pc_cur);
            if (instr_valid_d) begin
                chk("sb_occupancy", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("instr_d", instr_d, exp_q[0].w);
                    chk("instr_pc_d", instr_pc_d, exp_q[0].pc);
                    if (!stall_d) begin
                        dlog.push_back(exp_q[0].pc);
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
        end
        if (end_chk) begin
            chk("sb_drained", 32'(exp_q.size()), 32'd0);
            chk("delivered_min", 32'(delivered >= 100), 32'd1);
            chk("wait_timeouts", 32'(timeouts), 32'd0);
            chk("dlog_size", 32'(dlog.size() >= 3), 32'd1);
            if (dlog.size() >= 3) begin
                chk("first_pc0", dlog[0], 32'h0);
                chk("first_pc1", dlog[1], 32'h4);
                chk("first_pc2", dlog[2], 32'h8);
            end
        end
    end

    task automatic cyc(input bit rst, input bit st, input bit rd, input logic [31:0] rpc, input bit late);
        bit          act, held, rv;
        logic [31:0] tgt;
        ent_t        e;
        @(posedge clk);
        #1;
        act = !rst && !prev_rst;
        rv  = outst && (mwait == 0) && !rst;
        if (outst && mwait != 0) mwait--;
        reset       = rst;
        stall_d     = st;
        redirect_e  = rd;
        redirect_pc = rpc;
        imem_rvalid = rv || late;
        imem_rdata  = rv ? word_of(maddr) : $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
        tgt      = rpc & ~32'h3;
        e_mis    = mis_prev;
        mis_prev = act && rd && (rpc[1:0] != 2'b00);
`else
        tgt   = rpc;
        e_mis = 1'b0;
`endif
        held    = (exp_q.size() != 0);
        e_zero  = !act;
        e_free  = act && ((rv && (kill || rd || !st)) || (held && (rd || !st)));
        e_valid = act && ((held && !rd) || (rv && !kill && !rd && !st));
        e_req   = act && !held && !(outst && kill);
        e_pcn   = rd ? tgt : (pend ? pend_tgt : pc_cur + 32'd4);
        if (rst) begin
            exp_q.delete();
            pend = 1'b0;
        end else if (act) begin
            if (rd) exp_q.delete();
            else if (rv && !kill) begin
                e.pc = maddr;
                e.w  = word_of(maddr);
                exp_q.push_back(e);
            end
            if (e_free) pend = 1'b0;
            else if (rd) begin
                pend     = 1'b1;
                pend_tgt = tgt;
            end
        end
        prev_rst = rst;
        chk_en   = started;
        started  = 1'b1;
        @(negedge clk);
        if (rst || rv) begin
            outst = 1'b0;
            kill  = 1'b0;
        end else if (imem_req && !outst) begin
            outst = 1'b1;
            maddr = imem_addr;
            if (rand_lat) lat = $urandom_range(1, 3);
            mwait = lat - 1;
        end
        if (act && rd && outst) kill = 1'b1;
    endtask

    task automatic run_plain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // advance until a request is in flight (and, if asked, its response is due next cycle)
    task automatic idle_until(input bit want_due);
        int n = 0;
        while (!(outst && (!want_due || mwait == 0)) && n < 12) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            n++;
        end
        if (n >= 12) timeouts++;
    endtask

    initial begin
        int  stall_left;
        bit  t2_done;
        logic [31:0] rpc;

        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // sequential stream at latency 1, decode stalls 3 cycles on the word at 0x10
        lat = 1;
        stall_left = 0;
        t2_done = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (stall_left == 0 && !t2_done && outst && mwait == 0 && maddr == 32'h10) begin
                stall_left = 3;
                t2_done = 1'b1;
            end
            cyc(1'b0, stall_left > 0, 1'b0, 32'h0, 1'b0);
            if (stall_left > 0) stall_left--;
        end
        if (!t2_done) timeouts++;

        // redirect one cycle after the request, latency 3
        lat = 3;
        idle_until(1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        run_plain(10);

        // redirect coincident with rvalid, then redirect while holding
        lat = 2;
        idle_until(1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
        idle_until(1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h400, 1'b0);
        run_plain(6);

        // reset while dropping, stale rvalid arrives in the cycle after
        lat = 3;
        idle_until(1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h500, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        run_plain(8);

        // PC wrap and misaligned redirect target
        lat = 1;
        idle_until(1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        idle_until(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_plain(3);
        cyc(1'b0, 1'b0, 1'b1, 32'h202, 1'b0);
        run_plain(6);

        // randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 4))
                0: rpc = 32'h200;
                1: rpc = 32'h202;
                2: rpc = 32'hFFFF_FFFC;
                3: rpc = $urandom & 32'h0000_FFFC;
                default: rpc = $urandom;
            endcase
            cyc(1'b0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 7, rpc, 1'b0);
        end

        rand_lat = 1'b0;
        lat = 1;
        run_plain(30);

        @(posedge clk);
        #1;
        chk_en  = 1'b0;
        end_chk = 1'b1;
        @(negedge clk);
        #1;
        end_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
